// File: rtl/mem_pkg.sv
// mem_pkg: shared encodings for the data-memory access path.
//   size_e  : access width (byte / halfword / word / illegal)
//   op_e    : load or store
//   state_e : mem_data_handler FSM states
//   cmd_t   : command fields latched when a command is accepted
//   is_faulty() : illegal-size / misalignment check on the low address bits
package mem_pkg;

  localparam int unsigned DATA_W = 32;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10,
    SZ_ILL  = 2'b11
  } size_e;

  typedef enum logic {
    OP_LOAD  = 1'b0,
    OP_STORE = 1'b1
  } op_e;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_READ  = 3'd1,
    ST_MERGE = 3'd2,
    ST_WRITE = 3'd3,
    ST_DONE  = 3'd4
  } state_e;

  typedef struct packed {
    op_e               op;
    size_e             size;
    logic              sign;
    logic [1:0]        lane;
    logic [DATA_W-1:0] wdata;
  } cmd_t;

  // A command is faulty on an illegal size or a misaligned half/word address.
  function automatic logic is_faulty(input size_e size, input logic [1:0] lane);
    logic bad;
    case (size)
      SZ_BYTE: bad = 1'b0;
      SZ_HALF: bad = lane[0];
      SZ_WORD: bad = (lane != 2'b00);
      default: bad = 1'b1;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/mem_lane_align.sv
// mem_lane_align: little-endian lane handling for one 32-bit memory word.
//   rdata_i        : word read from memory
//   wdata_i        : store data (byte/half taken from its low bits)
//   size_i         : access width
//   sign_i         : 1 = sign-extend sub-word loads, 0 = zero-extend
//   lane_i         : byte address bits [1:0]
//   load_ext_c_o   : extracted and extended load value (word passes through)
//   merge_word_c_o : rdata_i with the addressed lane replaced by wdata_i
module mem_lane_align
  import mem_pkg::*;
(
  input  logic [DATA_W-1:0] rdata_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  size_e             size_i,
  input  logic              sign_i,
  input  logic [1:0]        lane_i,
  output logic [DATA_W-1:0] load_ext_c_o,
  output logic [DATA_W-1:0] merge_word_c_o
);

  logic [4:0]  byte_sh;
  logic [4:0]  half_sh;
  logic [7:0]  byte_v;
  logic [15:0] half_v;

  // Halfword lane is selected by addr[1] only.
  assign byte_sh = {lane_i, 3'b000};
  assign half_sh = {lane_i[1], 4'b0000};
  assign byte_v  = 8'(rdata_i >> byte_sh);
  assign half_v  = 16'(rdata_i >> half_sh);

  always_comb begin
    load_ext_c_o   = rdata_i;
    merge_word_c_o = wdata_i;
    case (size_i)
      SZ_BYTE: begin
        load_ext_c_o   = {{(DATA_W-8){sign_i & byte_v[7]}}, byte_v};
        merge_word_c_o = (rdata_i & ~(DATA_W'(32'h0000_00FF) << byte_sh))
                       | (DATA_W'(wdata_i[7:0]) << byte_sh);
      end
      SZ_HALF: begin
        load_ext_c_o   = {{(DATA_W-16){sign_i & half_v[15]}}, half_v};
        merge_word_c_o = (rdata_i & ~(DATA_W'(32'h0000_FFFF) << half_sh))
                       | (DATA_W'(wdata_i[15:0]) << half_sh);
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mem_data_handler.sv
// mem_data_handler: executes one byte/half/word load or store per command
// against a word-addressed, variable-latency req/ack data memory.
//   clock, reset          : clock (rising edge), asynchronous active-high reset
//   start, op, size, sign : command strobe and attributes (sampled in IDLE)
//   addr, store_data      : byte address and data to store
//   load_data             : extended load result, held until the next good load
//   busy, done, error     : status; done is a one-cycle pulse, error valid with it
//   mem_req .. mem_wdata  : memory request channel (held stable until ack)
//   mem_rdata, mem_ack    : memory response
// Sub-word stores read the word, merge the lane and write it back. The merged
// word is formed from mem_rdata at the read ack, so the MERGE cycle already
// presents the write request; MERGE falls through to WRITE only if the write
// is not acknowledged immediately.
module mem_data_handler
  import mem_pkg::*;
#(
  parameter int unsigned ADDR_W  = 30,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic              op,
  input  logic [1:0]        size,
  input  logic              sign,
  input  logic [31:0]       addr,
  input  logic [31:0]       store_data,
  output logic [31:0]       load_data,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
  input  logic              mem_ack
);

  localparam int unsigned CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

  state_e              state_q;
  cmd_t                cmd_q;
  logic [CNT_W-1:0]    cnt_q;
  logic [31:0]         load_data_q;
  logic                busy_q;
  logic                done_q;
  logic                error_q;
  logic                mem_req_q;
  logic                mem_we_q;
  logic [ADDR_W-1:0]   mem_addr_q;
  logic [31:0]         mem_wdata_q;

  logic [31:0]         load_ext_c;
  logic [31:0]         merge_word_c;
  logic                timeout_hit_c;
  logic                cmd_faulty_c;

  assign load_data = load_data_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign error     = error_q;
  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;

  // Lane logic works directly on mem_rdata so the result is ready at the ack edge.
  mem_lane_align u_lane (
    .rdata_i        (mem_rdata),
    .wdata_i        (cmd_q.wdata),
    .size_i         (cmd_q.size),
    .sign_i         (cmd_q.sign),
    .lane_i         (cmd_q.lane),
    .load_ext_c_o   (load_ext_c),
    .merge_word_c_o (merge_word_c)
  );

  // Last wait cycle before abort; TIMEOUT = 0 never aborts.
  assign timeout_hit_c = (TIMEOUT != 0) && (cnt_q == TO_LAST);
  assign cmd_faulty_c  = is_faulty(size_e'(size), addr[1:0]);

  // FSM, handshake and timeout.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      cmd_q       <= '0;
      cnt_q       <= '0;
      load_data_q <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      error_q     <= 1'b0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            cmd_q.op    <= op_e'(op);
            cmd_q.size  <= size_e'(size);
            cmd_q.sign  <= sign;
            cmd_q.lane  <= addr[1:0];
            cmd_q.wdata <= store_data;
            busy_q      <= 1'b1;
            cnt_q       <= '0;
            if (cmd_faulty_c) begin
              state_q <= ST_DONE;
              done_q  <= 1'b1;
              error_q <= 1'b1;
              if (op_e'(op) == OP_LOAD) load_data_q <= '0;
            end else if (op_e'(op) == OP_LOAD || size_e'(size) != SZ_WORD) begin
              state_q    <= ST_READ;
              mem_req_q  <= 1'b1;
              mem_we_q   <= 1'b0;
              mem_addr_q <= addr[ADDR_W+1:2];
            end else begin
              state_q     <= ST_WRITE;
              mem_req_q   <= 1'b1;
              mem_we_q    <= 1'b1;
              mem_addr_q  <= addr[ADDR_W+1:2];
              mem_wdata_q <= store_data;
            end
          end
        end

        ST_READ: begin
          if (mem_ack) begin
            cnt_q <= '0;
            if (cmd_q.op == OP_LOAD) begin
              state_q     <= ST_DONE;
              mem_req_q   <= 1'b0;
              done_q      <= 1'b1;
              error_q     <= 1'b0;
              load_data_q <= load_ext_c;
            end else begin
              // Request stays up and turns into the write of the merged word.
              state_q     <= ST_MERGE;
              mem_we_q    <= 1'b1;
              mem_wdata_q <= merge_word_c;
            end
          end else if (timeout_hit_c) begin
            state_q   <= ST_DONE;
            mem_req_q <= 1'b0;
            done_q    <= 1'b1;
            error_q   <= 1'b1;
            if (cmd_q.op == OP_LOAD) load_data_q <= '0;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end

        ST_MERGE, ST_WRITE: begin
          if (mem_ack) begin
            state_q   <= ST_DONE;
            mem_req_q <= 1'b0;
            mem_we_q  <= 1'b0;
            done_q    <= 1'b1;
            error_q   <= 1'b0;
          end else if (timeout_hit_c) begin
            state_q   <= ST_DONE;
            mem_req_q <= 1'b0;
            mem_we_q  <= 1'b0;
            done_q    <= 1'b1;
            error_q   <= 1'b1;
          end else begin
            state_q <= ST_WRITE;
            cnt_q   <= cnt_q + CNT_W'(1);
          end
        end

        ST_DONE: begin
          state_q <= ST_IDLE;
          done_q  <= 1'b0;
          error_q <= 1'b0;
          busy_q  <= 1'b0;
        end

        default: begin
          state_q   <= ST_IDLE;
          mem_req_q <= 1'b0;
          mem_we_q  <= 1'b0;
          done_q    <= 1'b0;
          error_q   <= 1'b0;
          busy_q    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/mem_data_handler.md
Name: mem_data_handler

Overview:
- Sits between the register bank's store-data/load-data ports and the word-addressed data memory.
- Executes one load or store per command: byte, halfword or word, little-endian. Sub-word loads are sign- or zero-extended. Sub-word stores use read-modify-write.
- Handshakes with a variable-latency memory (req/ack) and has a timeout.
- Its one-cycle `done` pulse is the register bank's write enable for load results and stall release.

Parameters:
- ADDR_W, 30, width of the word address driven to memory; mem_addr = addr[ADDR_W+1:2].
- TIMEOUT, 255, maximum cycles mem_req may wait for mem_ack before abort; 0 disables the timeout.

Ports:
- clock  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high
- start  in  1  command strobe; sampled only in IDLE
- op  in  1  0 = load, 1 = store
- size  in  2  00 = byte, 01 = halfword, 10 = word, 11 = illegal
- sign  in  1  load only: 1 = sign-extend, 0 = zero-extend
- addr  in  32  byte address
- store_data  in  32  data to store (register bank store-data output); byte/half taken from low bits
- load_data  out  32  extended load result (register bank load-data input)
- busy  out  1  high from the cycle after start is accepted until DONE exits
- done  out  1  one-cycle completion pulse
- error  out  1  valid with done: misaligned, illegal size, or timeout
- mem_req  out  1  memory request
- mem_we  out  1  1 = write
- mem_addr  out  ADDR_W  word address
- mem_wdata  out  32  write data
- mem_rdata  in  32  read data; valid in the cycle mem_ack = 1
- mem_ack  in  1  completes the current request

Behaviour:
- Reset (asynchronous, active-high; clock is `clock`):
  - All outputs go to 0; state goes to IDLE; timeout counter goes to 0.
  - Reset mid-operation abandons the access immediately: mem_req drops asynchronously and no done is produced.
- States: IDLE, READ, MERGE, WRITE, DONE.
- IDLE:
  - start = 1 latches op, size, sign, addr, store_data and drives busy = 1 next cycle.
  - The command is faulty if size = 11, or size = 01 with addr[0] = 1, or size = 10 with addr[1:0] != 0. A faulty command goes directly to DONE with error = 1 and no memory access.
  - Otherwise: a load goes to READ; a word store goes to WRITE; a sub-word store goes to READ.
- READ:
  - Drives mem_req = 1, mem_we = 0, mem_addr = latched addr[ADDR_W+1:2].
  - On mem_ack = 1, mem_rdata is captured. A load then goes to DONE; a sub-word store goes to MERGE.
- MERGE (one cycle):
  - Replaces the addressed lane of the captured word with store_data. Byte lane = addr[1:0]; half lane = addr[1].
  - Then goes to WRITE.
- WRITE:
  - Drives mem_req = 1, mem_we = 1, with the merged or full word on mem_wdata.
  - On mem_ack goes to DONE.
- Handshake rules:
  - mem_req, mem_we, mem_addr and mem_wdata stay stable while mem_req = 1 and mem_ack = 0.
  - mem_ack may arrive in the same cycle mem_req rises (zero-wait).
  - mem_ack is ignored when mem_req = 0.
- Timeout:
  - The counter clears on entry to READ or WRITE and increments each cycle without ack.
  - When the count reaches TIMEOUT (TIMEOUT != 0), mem_req drops and the block goes to DONE with error = 1.
  - A store that timed out in READ never writes.
- DONE (one cycle):
  - done = 1, and error is set as described above.
  - For a load, load_data = extracted lane, extended per sign. Word loads pass through unchanged.
  - Then returns to IDLE; busy = 0 in IDLE.
  - load_data holds its value until the next successful load. Errored loads force load_data = 0.
- start while not in IDLE is ignored; start is not queued.
- Latency with zero-wait memory, start accepted at cycle T:
  - load: done at T+2
  - word store: done at T+2
  - sub-word store: done at T+3
  - each memory wait cycle adds 1.

Decomposition:
- Shared package `mem_pkg`: size encodings (SZ_BYTE, SZ_HALF, SZ_WORD), op encodings, state enum, and a misalignment-check function.
- One combinational sub-module `mem_lane_align`: load lane extract plus sign/zero extension, and store lane merge. It is reused by the future instruction-fetch path.
- FSM, handshake and timeout stay in the top module.

Test Plan:
- Load byte, sign = 1, addr = 0x193, memory word 0x80FF_1234, zero-wait -> mem_addr = 0x64, done at T+2, load_data = 0xFFFF_FF80, error = 0.
- Load half, sign = 0, addr = 0x192, same word -> load_data = 0x0000_80FF.
- Store byte 0xAB to addr = 0x191, memory word 0x1122_3344, ack after 2 wait cycles in each phase -> READ then WRITE, mem_wdata = 0x1122_AB44, done at T+7.
- Store word to addr = 0x192 -> done at T+1 with error = 1, mem_req never asserted. Also size = 11 -> error = 1.
- TIMEOUT = 4, memory never acks a load -> mem_req high for exactly 4 cycles, then done with error = 1 and load_data = 0.
- Reset asserted while WRITE is waiting -> mem_req = 0 immediately, no done. After release, a new word load completes normally; start pulses during busy are ignored.
